glyph_scan_ctrl: RTL and testbench
==================================

Name: glyph_scan_ctrl

Overview:
- Sequences the 64x8 character ROM (4 glyphs x 16 rows x 8 pixels) to render one glyph as a serial pixel stream.
- ROM address is {char_code[1:0], row[3:0]}. The ROM is combinational; its data is valid in the same cycle the address is driven.
- Accepts character codes through a valid/ready handshake with a 1-entry pending buffer, so back-to-back glyphs render without idle gaps.
- Emits pixels MSB-first per row, row 0 first, under downstream valid/ready backpressure. Sits between the text/score logic and the display shifter.

Parameters:
- CHAR_BITS, 2, width of the character code (number of glyphs = 2^CHAR_BITS).
- ROW_BITS, 4, width of the row index (rows per glyph = 2^ROW_BITS = 16).
- COLS, 8, pixels per row; equals the ROM data width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- char_valid  in  1  a character code is offered.
- char_code  in  CHAR_BITS  glyph to render.
- char_ready  out  1  block can accept a code this cycle.
- rom_addr  out  CHAR_BITS+ROW_BITS  address to the char ROM; registered.
- rom_data  in  COLS  ROM row data (combinational from rom_addr).
- pix_valid  out  1  pixel_out is valid.
- pix_ready  in  1  downstream accepts the pixel.
- pixel_out  out  1  current pixel (1 = lit).
- row_idx  out  ROW_BITS  row of the current pixel.
- col_idx  out  3  column of the current pixel (0 = MSB of the ROM byte).
- glyph_start  out  1  high with the pixel at row 0, col 0.
- busy  out  1  state != IDLE.
- done  out  1  single-cycle pulse after the last pixel of a glyph transfers.

Behaviour:
- Reset value of every output is 0 except char_ready=1. Internal state on reset: state=IDLE, pending buffer empty, shift register 0, cur_char 0, row 0, col 0.
- Reset mid-glyph aborts the glyph: the pending code is discarded and no done pulse is produced.
- Accept rule: a code is accepted when char_valid & char_ready. char_ready = !pending_full; in IDLE this is always 1.
- States:
  - IDLE: on accept, load cur_char and set row=0. Go to FETCH. Pending stays empty.
  - FETCH: rom_addr = {cur_char,row} is already registered. At the end of the cycle, load shift_reg <= rom_data and set col=0. Go to SHIFT. pix_valid=0 during FETCH (one bubble per row).
  - SHIFT: pix_valid=1, pixel_out = shift_reg[COLS-1]. On pix_valid & pix_ready, shift left by 1 and increment col. With pix_ready=0, hold pixel_out, row_idx and col_idx stable.
- End of row: transfer at col=COLS-1.
  - If row < 15: increment row, update rom_addr, go to FETCH.
  - If row = 15 (glyph end): done=1 on the next cycle.
- Next action after glyph end, checked in this order:
  - Pending full: load cur_char from pending, clear pending, row=0, go to FETCH.
  - Pending empty and a code is accepted in the same cycle: that code becomes cur_char directly, go to FETCH.
  - Otherwise: go to IDLE.
- Codes accepted while busy and not at glyph end are written to pending.
- A code arriving with pending full is not accepted (char_ready=0). The requester holds char_valid; nothing is dropped.
- Latency with pix_ready held at 1 and the code accepted at cycle T:
  - Row r fetch occurs at cycle T+1+9r.
  - Row r pixels occupy cycles T+2+9r through T+9+9r.
  - Last pixel is at T+144; done pulses at T+145.
  - A back-to-back glyph's FETCH occurs at T+145.
- busy=1 in FETCH and SHIFT. done can coincide with busy=1 when a back-to-back glyph starts.
- glyph_start=1 only while row=0, col=0 and pix_valid=1. It stays high across stall cycles.

Test Plan:
- Reset, then char_code=0 accepted, pix_ready=1: row 0 pixels are 0,0,0,1,1,0,0,0; row 14 is all 1s; rom_addr steps 0x00..0x0F; done pulses at T+145.
- char_code=3 with pix_ready toggling 1/0 every cycle: the pixel stream is unchanged (row 7 = 11111111, row 8 = 11111111, row 9 = 00000011); outputs hold on stall cycles; done is delayed by exactly the stall count.
- Codes 1, then 2 offered while busy: code 2 is held in pending and char_ready=0 until it is promoted. A third code is blocked. The glyph-2 FETCH (rom_addr=0x20) follows glyph 1's last pixel with no IDLE cycle.
- Code offered in exactly the glyph-end cycle with pending empty: it is accepted and FETCH of the new glyph occurs next cycle; no IDLE.
- reset=1 asserted at row 6, col 3 with a code pending: next cycle busy=0, pix_valid=0, char_ready=1, no done pulse. A new code 1 then renders from row 0 (00111100).
- Idle with char_valid=0 for 50 cycles: busy=0, pix_valid=0, done=0 throughout.

Source files
------------

// File: rtl/glyph_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : glyph_scan_ctrl_if
//  Description : Bundles the character handshake, the character-ROM port and
//                the serial pixel stream of glyph_scan_ctrl. The master side
//                (text logic, ROM and display shifter) drives the inputs. The
//                slave side is the scan controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface glyph_scan_ctrl_if #(
    parameter int CHAR_BITS = 2,
    parameter int ROW_BITS  = 4,
    parameter int COLS      = 8
);
    localparam int COL_BITS = $clog2(COLS);

    logic                          char_valid;
    logic [CHAR_BITS-1:0]          char_code;
    logic                          char_ready;
    logic [CHAR_BITS+ROW_BITS-1:0] rom_addr;
    logic [COLS-1:0]               rom_data;
    logic                          pix_valid;
    logic                          pix_ready;
    logic                          pixel_out;
    logic [ROW_BITS-1:0]           row_idx;
    logic [COL_BITS-1:0]           col_idx;
    logic                          glyph_start;
    logic                          busy;
    logic                          done;

    modport master (
        output char_valid, char_code, rom_data, pix_ready,
        input  char_ready, rom_addr, pix_valid, pixel_out,
               row_idx, col_idx, glyph_start, busy, done
    );

    modport slave (
        input  char_valid, char_code, rom_data, pix_ready,
        output char_ready, rom_addr, pix_valid, pixel_out,
               row_idx, col_idx, glyph_start, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/glyph_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : glyph_scan_ctrl
//  Description : Walks the character ROM one row at a time and serialises each
//                row MSB-first onto a valid/ready pixel stream. A one-entry
//                pending buffer lets a following glyph start right after the
//                last pixel of the current glyph, with no idle cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module glyph_scan_ctrl #(
    parameter int CHAR_BITS = 2,
    parameter int ROW_BITS  = 4,
    parameter int COLS      = 8
) (
    input  wire logic         clk,
    input  wire logic         reset,
    glyph_scan_ctrl_if.slave  bus
);
    localparam int COL_BITS = $clog2(COLS);
    localparam logic [ROW_BITS-1:0] c_row_last = '1;
    localparam logic [COL_BITS-1:0] c_col_last = COL_BITS'(COLS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    state_t                        state_q,     state_d;
    logic [CHAR_BITS-1:0]          cur_char_q,  cur_char_d;
    logic [CHAR_BITS-1:0]          pend_code_q, pend_code_d;
    logic                          pend_full_q, pend_full_d;
    logic [COLS-1:0]               shift_q,     shift_d;
    logic [ROW_BITS-1:0]           row_q,       row_d;
    logic [COL_BITS-1:0]           col_q,       col_d;
    logic [CHAR_BITS+ROW_BITS-1:0] rom_addr_q,  rom_addr_d;
    logic                          done_q,      done_d;

    logic w_accept;
    logic w_xfer;
    logic w_row_end;
    logic w_glyph_end;

    assign w_accept    = bus.char_valid & ~pend_full_q;
    assign w_xfer      = (state_q == S_SHIFT) & bus.pix_ready;
    assign w_row_end   = w_xfer & (col_q == c_col_last);
    assign w_glyph_end = w_row_end & (row_q == c_row_last);

    // Next-state logic: fetch a row, shift out its pixels, chain to the next glyph
    always_comb begin
        state_d     = state_q;
        cur_char_d  = cur_char_q;
        pend_code_d = pend_code_q;
        pend_full_d = pend_full_q;
        shift_d     = shift_q;
        row_d       = row_q;
        col_d       = col_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    cur_char_d = bus.char_code;
                    row_d      = '0;
                    col_d      = '0;
                    state_d    = S_FETCH;
                end
            end

            S_FETCH: begin
                // ROM data is combinational on the registered address
                shift_d = bus.rom_data;
                col_d   = '0;
                state_d = S_SHIFT;
            end

            S_SHIFT: begin
                if (w_xfer) begin
                    shift_d = shift_q << 1;
                    col_d   = col_q + COL_BITS'(1);
                end
                if (w_row_end) begin
                    col_d = '0;
                    if (!w_glyph_end) begin
                        row_d   = row_q + ROW_BITS'(1);
                        state_d = S_FETCH;
                    end else begin
                        done_d = 1'b1;
                        row_d  = '0;
                        // A buffered code takes priority over one offered now
                        if (pend_full_q) begin
                            cur_char_d  = pend_code_q;
                            pend_full_d = 1'b0;
                            state_d     = S_FETCH;
                        end else if (w_accept) begin
                            cur_char_d = bus.char_code;
                            state_d    = S_FETCH;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Codes arriving mid-glyph wait in the pending buffer
        if (w_accept && (state_q != S_IDLE) && !w_glyph_end) begin
            pend_code_d = bus.char_code;
            pend_full_d = 1'b1;
        end

        // Address always tracks the glyph/row that the next FETCH will read
        rom_addr_d = {cur_char_d, row_d};
    end

    // State register with synchronous reset; reset aborts any glyph in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cur_char_q  <= '0;
            pend_code_q <= '0;
            pend_full_q <= 1'b0;
            shift_q     <= '0;
            row_q       <= '0;
            col_q       <= '0;
            rom_addr_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_char_q  <= cur_char_d;
            pend_code_q <= pend_code_d;
            pend_full_q <= pend_full_d;
            shift_q     <= shift_d;
            row_q       <= row_d;
            col_q       <= col_d;
            rom_addr_q  <= rom_addr_d;
            done_q      <= done_d;
        end
    end

    assign bus.char_ready  = ~pend_full_q;
    assign bus.rom_addr    = rom_addr_q;
    assign bus.pix_valid   = (state_q == S_SHIFT);
    assign bus.pixel_out   = shift_q[COLS-1];
    assign bus.row_idx     = row_q;
    assign bus.col_idx     = col_q;
    assign bus.glyph_start = (state_q == S_SHIFT) && (row_q == '0) && (col_q == '0);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_glyph_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_glyph_scan_ctrl
//  Description : Self-checking bench for glyph_scan_ctrl. A queue-based model
//                of outstanding glyphs predicts handshake, pixel stream and
//                done timing cycle by cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_glyph_scan_ctrl;
    localparam int CHAR_BITS = 2;
    localparam int ROW_BITS  = 4;
    localparam int COLS      = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    glyph_scan_ctrl_if #(.CHAR_BITS(CHAR_BITS), .ROW_BITS(ROW_BITS), .COLS(COLS)) bus ();

    glyph_scan_ctrl #(.CHAR_BITS(CHAR_BITS), .ROW_BITS(ROW_BITS), .COLS(COLS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Character ROM: 4 glyphs x 16 rows
    logic [7:0] rom [64];
    assign bus.rom_data = rom[bus.rom_addr];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: queue of glyph codes (front = rendering, second = waiting)
    int q[$];
    int row_m, col_m;
    bit bubble_m, done_m;
    int cyc = 0;
    int acc_cyc, done_cyc, stall_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: apply inputs, compare against model, advance model
    task automatic tick(input bit v, input int c, input bit pr);
        bit busy_e, pv_e, acc, xfer, rowend, started;
        logic [7:0] b;
        bus.char_valid = v;
        bus.char_code  = c[1:0];
        bus.pix_ready  = pr;
        #1;
        busy_e = q.size() > 0;
        pv_e   = busy_e && !bubble_m;
        chk("busy",       32'(bus.busy),       32'(busy_e));
        chk("char_ready", 32'(bus.char_ready), 32'(q.size() < 2));
        chk("pix_valid",  32'(bus.pix_valid),  32'(pv_e));
        chk("done",       32'(bus.done),       32'(done_m));
        if (busy_e && bubble_m)
            chk("rom_addr", 32'(bus.rom_addr), 32'(q[0] * 16 + row_m));
        if (pv_e) begin
            b = rom[q[0] * 16 + row_m];
            chk("pixel",       32'(bus.pixel_out),   32'(b[7 - col_m]));
            chk("row_idx",     32'(bus.row_idx),     32'(row_m));
            chk("col_idx",     32'(bus.col_idx),     32'(col_m));
            chk("glyph_start", 32'(bus.glyph_start), 32'(row_m == 0 && col_m == 0));
            if (!pr) stall_cnt++;
        end else begin
            chk("glyph_start_idle", 32'(bus.glyph_start), 32'(0));
        end
        if (bus.done === 1'b1 && done_cyc < 0) done_cyc = cyc;

        acc     = v && (q.size() < 2);
        xfer    = pv_e && pr;
        rowend  = 1'b0;
        started = 1'b0;
        done_m  = 1'b0;
        if (xfer) begin
            col_m++;
            if (col_m == COLS) begin
                col_m  = 0;
                rowend = 1'b1;
                row_m++;
                if (row_m == 16) begin
                    row_m = 0;
                    void'(q.pop_front());
                    done_m = 1'b1;
                end
            end
        end
        if (acc) begin
            if (q.size() == 0) begin
                started = 1'b1;
                row_m   = 0;
                col_m   = 0;
            end
            q.push_back(c & 3);
            if (acc_cyc < 0) acc_cyc = cyc;
        end
        bubble_m = (q.size() > 0) && (rowend || started);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        bus.char_valid = 1'b0;
        bus.pix_ready  = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b0;
        q.delete();
        row_m = 0; col_m = 0; bubble_m = 1'b0; done_m = 1'b0;
    endtask

    function automatic bit pr_of(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (k % 2) == 0;
        return $urandom_range(0, 3) != 0;
    endfunction

    // Drain all outstanding glyphs, then a few idle cycles to observe done
    task automatic run_until_idle(input int mode);
        int k = 0;
        while (q.size() > 0 && k < 3000) begin
            tick(1'b0, 0, pr_of(mode, k));
            k++;
        end
        repeat (3) tick(1'b0, 0, 1'b1);
        chk("idle_after_run", 32'(bus.busy), 32'(0));
    endtask

    initial begin
        int k;
        bit waiting;
        for (int i = 0; i < 64; i++) rom[i] = 8'($urandom);
        rom[0]      = 8'h18;
        rom[14]     = 8'hFF;
        rom[16]     = 8'h3C;
        rom[3*16+7] = 8'hFF;
        rom[3*16+8] = 8'hFF;
        rom[3*16+9] = 8'h03;
        bus.char_valid = 1'b0;
        bus.char_code  = '0;
        bus.pix_ready  = 1'b0;
        @(negedge clk);
        do_reset(3);

        // Reset state
        chk("rst_rom_addr",    32'(bus.rom_addr),    32'(0));
        chk("rst_pixel",       32'(bus.pixel_out),   32'(0));
        chk("rst_row",         32'(bus.row_idx),     32'(0));
        chk("rst_col",         32'(bus.col_idx),     32'(0));
        chk("rst_char_ready",  32'(bus.char_ready),  32'(1));
        chk("rst_busy",        32'(bus.busy),        32'(0));
        chk("rst_done",        32'(bus.done),        32'(0));
        chk("rst_pix_valid",   32'(bus.pix_valid),   32'(0));

        // Glyph 0, no backpressure: done at accept + 145
        acc_cyc = -1; done_cyc = -1;
        tick(1'b1, 0, 1'b1);
        run_until_idle(0);
        chk("latency_glyph0", 32'(done_cyc - acc_cyc), 32'(145));

        // Glyph 3, ready toggling: done delayed by exactly the stall count
        acc_cyc = -1; done_cyc = -1; stall_cnt = 0;
        tick(1'b1, 3, 1'b1);
        run_until_idle(1);
        chk("latency_glyph3_stall", 32'(done_cyc - acc_cyc), 32'(145 + stall_cnt));

        // Codes 1 then 2 while busy; third code held until there is room
        tick(1'b1, 1, 1'b1);
        tick(1'b1, 2, 1'b1);
        waiting = 1'b1; k = 0;
        while (waiting && k < 400) begin
            waiting = !(q.size() < 2);
            tick(1'b1, 3, 1'b1);
            k++;
        end
        run_until_idle(0);

        // Code offered exactly in the glyph-end cycle
        tick(1'b1, 2, 1'b1);
        k = 0;
        while (!(row_m == 15 && col_m == 7 && !bubble_m) && k < 400) begin
            tick(1'b0, 0, 1'b1);
            k++;
        end
        tick(1'b1, 1, 1'b1);
        chk("glyph_end_chain_busy", 32'(bus.busy), 32'(1));
        run_until_idle(0);

        // Reset at row 6, col 3 with a code pending
        tick(1'b1, 0, 1'b1);
        tick(1'b1, 3, 1'b1);
        k = 0;
        while (!(row_m == 6 && col_m == 3 && !bubble_m) && k < 400) begin
            tick(1'b0, 0, 1'b1);
            k++;
        end
        do_reset(1);
        tick(1'b0, 0, 1'b1);
        tick(1'b1, 1, 1'b1);
        run_until_idle(0);

        // Long idle stretch
        repeat (50) tick(1'b0, $urandom_range(0, 3), 1'b1);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 999) == 0) do_reset(1);
            else tick($urandom_range(0, 3) == 0, $urandom_range(0, 3), $urandom_range(0, 3) != 0);
        end
        run_until_idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
